// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multicycle RV32I datapath built around one ALU and one
// unified instruction/data memory. Each instruction walks through a short
// sequence of states; every datapath enable and mux select is decoded from
// the current state (plus the latched instruction fields and, in a few
// states, mem_ready / Zero). Memory accesses wait on a variable-latency
// mem_ready handshake.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   op/funct3/funct7b5  fields of the latched instruction register
//   Zero            ALU zero flag (branch resolution)
//   mem_ready       memory finishes the current access this cycle
//   mem_req, AdrSrc, MemWrite          memory interface controls
//   IRWrite, PCWrite, RegWrite         register enables
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl   datapath selects
//   instr_done      one-cycle pulse in the last cycle of every instruction
//   illegal         sticky flag, set when an unknown opcode is trapped
//   retired         wrapping count of completed instructions
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  Zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [2:0]            ImmSrc,
    output logic [3:0]            ALUControl,
    output logic                  instr_done,
    output logic                  illegal,
    output logic [DATA_WIDTH-1:0] retired
);

    // Opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operations
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    state_t                  state_q, state_d;
    logic                    jalr_q, jalr_d;   // ALUWB must write OldPC+4 after JALR
    logic                    illegal_q;
    logic [DATA_WIDTH-1:0]   retired_q;

    // ALU operation for register and immediate arithmetic. SUB exists only
    // for R-type: in an addi, instr[30] is part of the immediate.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       is_rtype);
        logic [3:0] ctl;
        case (f3)
            3'b000:  ctl = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  ctl = ALU_SLL;
            3'b010:  ctl = ALU_SLT;
            3'b011:  ctl = ALU_SLTU;
            3'b100:  ctl = ALU_XOR;
            3'b101:  ctl = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  ctl = ALU_OR;
            default: ctl = ALU_AND;
        endcase
        return ctl;
    endfunction

    // Branch compare: equality via SUB, signed/unsigned ordering via SLT(U).
    // The ALU result of SLT(U) is 1 when "less than", so Zero=0 means less.
    function automatic logic [3:0] branch_alu(input logic [2:0] f3);
        logic [3:0] ctl;
        case (f3[2:1])
            2'b10:   ctl = ALU_SLT;
            2'b11:   ctl = ALU_SLTU;
            default: ctl = ALU_SUB;
        endcase
        return ctl;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z);
        logic taken;
        case (f3)
            3'b000:  taken = z;        // beq
            3'b001:  taken = !z;       // bne
            3'b100:  taken = !z;       // blt
            3'b101:  taken = z;        // bge
            3'b110:  taken = !z;       // bltu
            3'b111:  taken = z;        // bgeu
            default: taken = 1'b0;     // reserved encodings never branch
        endcase
        return taken;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        jalr_d  = jalr_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH: begin
                jalr_d = 1'b0;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECR;
                    OP_ITYPE:  state_d = S_EXECI;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_LUI:    state_d = S_LUI;
                    OP_AUIPC:  state_d = S_AUIPC;
                    default:   state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR,
            S_EXECI,
            S_JAL,
            S_LUI,
            S_AUIPC:    state_d = S_ALUWB;
            S_JALR: begin
                jalr_d  = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                jalr_d  = 1'b0;
                state_d = S_FETCH;
            end
            S_BRANCH:   state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;   // only reset leaves TRAP
            default:    state_d = S_RESET;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore on state; mem_ready/Zero only gate strobes)
    // ------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = ALU_ADD;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 goes straight through the ALU into the PC
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                // Speculatively compute OldPC+imm into ALUOut; JAL needs the
                // J-immediate here because its target is taken from ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decode(funct3, funct7b5, 1'b1);
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_decode(funct3, funct7b5, 1'b0);
            end
            S_BRANCH: begin
                // Branch target already sits in ALUOut from DECODE
                ALUSrcA    = 2'b10;
                ALUControl = branch_alu(funct3);
                PCWrite    = branch_taken(funct3, Zero);
                instr_done = 1'b1;
            end
            S_JAL: begin
                // PC <- ALUOut (target); ALU computes OldPC+4 into ALUOut
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                // Target rs1+imm comes from the live ALU result
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                if (jalr_q) begin
                    // ALUOut was overwritten by the target; recompute OldPC+4
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            jalr_q    <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            jalr_q  <= jalr_d;
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (instr_done) begin
                retired_q <= retired_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Each instruction pushes its per-cycle
// stimulus (mem_ready, Zero) together with the expected control vector onto a
// scoreboard queue; drain() then replays the queue one clock at a time and
// checks the DUT outputs and the retired counter. A 3-bit counter width is
// used so that wrap-around is reached within the sequence.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int DW = 3;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b0001;
    localparam logic [3:0] SRA  = 4'b1000;
    localparam logic [3:0] SLTU = 4'b1001;

    logic          clk;
    logic          rst_n;
    logic [6:0]    op;
    logic [2:0]    funct3;
    logic          funct7b5;
    logic          Zero;
    logic          mem_ready;
    logic          mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
    logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]    ImmSrc;
    logic [3:0]    ALUControl;
    logic          instr_done, illegal;
    logic [DW-1:0] retired;

    multicycle_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .instr_done (instr_done),
        .illegal    (illegal),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic        z;
        logic [20:0] exp;
        string       tag;
    } step_t;

    step_t         sb_q[$];
    int            n_checks = 0;
    int            n_fails  = 0;
    logic [DW-1:0] exp_ret  = '0;

    // {mem_req,AdrSrc,MemWrite,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,
    //  ALUSrcB,ImmSrc,ALUControl,instr_done,illegal}
    function automatic logic [20:0] mk(input logic req, adr, mw, irw, pcw, rw,
                                       input logic [1:0] rs, sa, sb,
                                       input logic [2:0] imm,
                                       input logic [3:0] alu,
                                       input logic done, ill);
        return {req, adr, mw, irw, pcw, rw, rs, sa, sb, imm, alu, done, ill};
    endfunction

    function automatic logic [20:0] observed();
        return {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, illegal};
    endfunction

    task automatic push(input logic mr, input logic z, input logic [20:0] e,
                        input string tag);
        step_t s;
        s.mr = mr; s.z = z; s.exp = e; s.tag = tag;
        sb_q.push_back(s);
    endtask

    task automatic check_vec(input string tag, input logic [20:0] e);
        logic [20:0] o;
        o = observed();
        n_checks++;
        assert (o === e) else begin
            n_fails++;
            $error("FAIL %s: ctrl observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic check_ret(input string tag);
        n_checks++;
        assert (retired === exp_ret) else begin
            n_fails++;
            $error("FAIL %s retired: observed %0d expected %0d", tag, retired, exp_ret);
        end
    endtask

    // Entered on a falling edge; each popped step occupies one clock.
    task automatic drain();
        step_t s;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            mem_ready = s.mr;
            Zero      = s.z;
            #1;
            check_vec(s.tag, s.exp);
            check_ret(s.tag);
            $display("step %-10s ctrl=%b retired=%0d", s.tag, observed(), retired);
            if (s.exp[1] && rst_n) begin
                exp_ret = (exp_ret == {DW{1'b1}}) ? '0 : exp_ret + 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    logic [20:0] v_zero, v_fetch, v_fetch_wait, v_dec, v_dec_jal, v_aluwb, v_execr_add;

    task automatic push_front_end(input logic [20:0] dec);
        push(1'b1, 1'b0, v_fetch, "FETCH");
        push(1'b1, 1'b0, dec,     "DECODE");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        v_zero       = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,ADD,0,0);
        v_fetch      = mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,3'b000,ADD,0,0);
        v_fetch_wait = mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,ADD,0,0);
        v_dec        = mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b010,ADD,0,0);
        v_dec_jal    = mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b011,ADD,0,0);
        v_aluwb      = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,ADD,1,0);
        v_execr_add  = mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,ADD,0,0);

        rst_n = 1'b0; mem_ready = 1'b0; Zero = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);
        @(negedge clk);

        // Reset held across an edge, then released: one more RESET cycle
        push(1'b1, 1'b0, v_zero, "RST_HELD");
        drain();
        rst_n = 1'b1;
        push(1'b1, 1'b0, v_zero, "RESET");

        // add
        push_front_end(v_dec);
        push(1'b1, 1'b0, v_execr_add, "EXECR_ADD");
        push(1'b1, 1'b0, v_aluwb, "ALUWB");
        drain();

        // sub
        set_instr(7'b0110011, 3'b000, 1'b1);
        push_front_end(v_dec);
        push(1'b1, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,SUB,0,0), "EXECR_SUB");
        push(1'b1, 1'b0, v_aluwb, "ALUWB");
        drain();

        // addi with instr[30]=1 is still ADD
        set_instr(7'b0010011, 3'b000, 1'b1);
        push_front_end(v_dec);
        push(1'b1, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,ADD,0,0), "EXECI_ADDI");
        push(1'b1, 1'b0, v_aluwb, "ALUWB");
        drain();

        // srai
        set_instr(7'b0010011, 3'b101, 1'b1);
        push_front_end(v_dec);
        push(1'b1, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,SRA,0,0), "EXECI_SRAI");
        push(1'b1, 1'b0, v_aluwb, "ALUWB");
        drain();

        // lui
        set_instr(7'b0110111, 3'b000, 1'b0);
        push_front_end(v_dec);
        push(1'b1, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b11,2'b01,3'b100,ADD,0,0), "LUI");
        push(1'b1, 1'b0, v_aluwb, "ALUWB");
        drain();

        // jal: J-immediate in DECODE
        set_instr(7'b1101111, 3'b000, 1'b0);
        push_front_end(v_dec_jal);
        push(1'b1, 1'b0, mk(0,0,0,0,1,0,2'b00,2'b01,2'b10,3'b000,ADD,0,0), "JAL");
        push(1'b1, 1'b0, v_aluwb, "ALUWB");
        drain();

        // jalr: write-back recomputes OldPC+4
        set_instr(7'b1100111, 3'b000, 1'b0);
        push_front_end(v_dec);
        push(1'b1, 1'b0, mk(0,0,0,0,1,0,2'b10,2'b10,2'b01,3'b000,ADD,0,0), "JALR");
        push(1'b1, 1'b0, mk(0,0,0,0,0,1,2'b10,2'b01,2'b10,3'b000,ADD,1,0), "ALUWB_JALR");
        drain();

        // add after jalr: write-back back to plain ALUOut (counter wraps here)
        set_instr(7'b0110011, 3'b000, 1'b0);
        push_front_end(v_dec);
        push(1'b1, 1'b0, v_execr_add, "EXECR_ADD");
        push(1'b1, 1'b0, v_aluwb, "ALUWB");
        drain();

        // lw with three wait cycles: 8 cycles total
        set_instr(7'b0000011, 3'b010, 1'b0);
        push_front_end(v_dec);
        push(1'b1, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,ADD,0,0), "MEMADR_LD");
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 1'b0, mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,3'b000,ADD,0,0), "MEMRD_WAIT");
        end
        push(1'b1, 1'b0, mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,3'b000,ADD,0,0), "MEMRD_DONE");
        push(1'b1, 1'b0, mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,ADD,1,0), "MEMWB");
        drain();

        // bne not taken (Zero=1), bne taken (Zero=0), bltu taken (Zero=0)
        set_instr(7'b1100011, 3'b001, 1'b0);
        push_front_end(v_dec);
        push(1'b1, 1'b1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,SUB,1,0), "BNE_NT");
        drain();
        push_front_end(v_dec);
        push(1'b1, 1'b0, mk(0,0,0,0,1,0,2'b00,2'b10,2'b00,3'b000,SUB,1,0), "BNE_T");
        drain();
        set_instr(7'b1100011, 3'b110, 1'b0);
        push_front_end(v_dec);
        push(1'b1, 1'b0, mk(0,0,0,0,1,0,2'b00,2'b10,2'b00,3'b000,SLTU,1,0), "BLTU_T");
        drain();

        // sw: single write cycle, retires in MEMWRITE
        set_instr(7'b0100011, 3'b010, 1'b0);
        push_front_end(v_dec);
        push(1'b1, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,ADD,0,0), "MEMADR_ST");
        push(1'b1, 1'b0, mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,3'b000,ADD,1,0), "MEMWRITE");
        drain();

        // lw with a slow fetch, aborted by reset in the middle of MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0);
        push(1'b0, 1'b0, v_fetch_wait, "FETCH_WAIT");
        push_front_end(v_dec);
        push(1'b1, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,ADD,0,0), "MEMADR_LD");
        push(1'b0, 1'b0, mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,3'b000,ADD,0,0), "MEMRD_WAIT");
        push(1'b0, 1'b0, mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,3'b000,ADD,0,0), "MEMRD_WAIT");
        drain();
        #3 rst_n = 1'b0;
        exp_ret = '0;
        #1;
        check_vec("RST_MIDREAD", v_zero);
        check_ret("RST_MIDREAD");
        $display("step %-10s ctrl=%b retired=%0d", "RST_MID", observed(), retired);
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b1, 1'b0, v_zero, "RESET");

        // illegal opcode: trap, no further memory requests
        set_instr(7'b0000000, 3'b000, 1'b0);
        push_front_end(v_dec);
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,ADD,0,1), "TRAP");
        end
        drain();

        // reset pulse clears the sticky flag, then a normal add retires
        #3 rst_n = 1'b0;
        #1;
        check_vec("RST_TRAP", v_zero);
        $display("step %-10s ctrl=%b retired=%0d", "RST_TRAP", observed(), retired);
        @(negedge clk);
        rst_n = 1'b1;
        set_instr(7'b0110011, 3'b000, 1'b0);
        push(1'b1, 1'b0, v_zero, "RESET");
        push_front_end(v_dec);
        push(1'b1, 1'b0, v_execr_add, "EXECR_ADD");
        push(1'b1, 1'b0, v_aluwb, "ALUWB");
        push(1'b0, 1'b0, v_fetch_wait, "FETCH_WAIT");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
